dlx_fetch_unit: RTL and testbench

Instruction fetch unit for the DLX core, acting as the requester side of the instruction-memory read interface. It owns the program counter and drives word addresses to the instruction ROM. It captures the returned instruction words into a 2-entry prefetch buffer and presents them to the decode stage over a valid/ready handshake. It handles branch redirects (flush and reload PC) and halt.

---
 rtl/dlx_pkg.sv | 34 +++
 rtl/dlx_fetch_fifo.sv | 92 +++++++++
 rtl/dlx_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_dlx_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX core front end.
//   fetch_state_e : fetch unit state encoding (IDLE / FETCH / HALTED)
//   DLX_INST_W    : instruction width
//   DLX_ADDR_W    : byte address width
//   DLX_PC_STEP   : PC increment per sequential instruction (bytes)
//   slot_free     : prefetch buffer space check for a 2-entry buffer
// -----------------------------------------------------------------------------
package dlx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam int DLX_INST_W  = 32;
    localparam int DLX_ADDR_W  = 32;
    localparam int DLX_PC_STEP = 4;

    // A slot is available when the buffer is not full, or when it is full
    // but the head leaves in the same cycle.
    function automatic logic slot_free(input logic [1:0] count, input logic pop);
        logic free_v;
        if (count < 2'd2) begin
            free_v = 1'b1;
        end else begin
            free_v = pop;
        end
        return free_v;
    endfunction

endpackage

// File: rtl/dlx_fetch_fifo.sv
// -----------------------------------------------------------------------------
// dlx_fetch_fifo
// Two-entry in-order prefetch buffer built as a shift pair: slot 0 is always
// the head, so the head output comes straight from a register.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (clears count and storage)
//   push    : write wr_data behind the current contents
//   pop     : drop the head entry
//   flush   : discard every entry; wins over push, may coincide with pop
//   wr_data : entry to push
//   count   : number of valid entries (0..2)
//   head    : oldest entry
// The caller must not push into a full buffer unless it pops in the same
// cycle, and must not pop an empty buffer.
// -----------------------------------------------------------------------------
module dlx_fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [1:0]       count_r;
    logic [1:0]       count_n_s;
    logic [WIDTH-1:0] slot0_r;
    logic [WIDTH-1:0] slot1_r;
    logic [WIDTH-1:0] slot0_n_s;
    logic [WIDTH-1:0] slot1_n_s;

    // Next-state of the occupancy count and both storage slots.
    always_comb begin
        count_n_s = count_r;
        slot0_n_s = slot0_r;
        slot1_n_s = slot1_r;
        if (flush) begin
            // A concurrent pop has already been consumed by the reader;
            // stale data may remain in the slots, only the count matters.
            count_n_s = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_n_s = wr_data;
                    end else begin
                        slot1_n_s = wr_data;
                    end
                    count_n_s = count_r + 2'd1;
                end
                2'b01: begin
                    slot0_n_s = slot1_r;
                    count_n_s = count_r - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind
                    // whatever survives the pop.
                    if (count_r == 2'd1) begin
                        slot0_n_s = wr_data;
                    end else begin
                        slot0_n_s = slot1_r;
                        slot1_n_s = wr_data;
                    end
                end
                default: begin
                    count_n_s = count_r;
                end
            endcase
        end
    end

    // Storage and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            slot0_r <= '0;
            slot1_r <= '0;
        end else begin
            count_r <= count_n_s;
            slot0_r <= slot0_n_s;
            slot1_r <= slot1_n_s;
        end
    end

    assign count = count_r;
    assign head  = slot0_r;

endmodule

// File: rtl/dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// dlx_fetch_unit
// Instruction fetch for the DLX core. Owns the PC, reads a combinational
// instruction ROM, buffers up to two fetched words and hands them to decode
// over valid/ready. Supports branch redirect (flush + reload) and halt.
//   clk_i / rst_n_i : clock, asynchronous active-low reset
//   imem_addr_o     : word address to the ROM (pc >> 2)
//   imem_en_o       : ROM word is captured into the buffer this cycle
//   imem_data_i     : ROM word for imem_addr_o, same cycle
//   inst_o          : head instruction
//   inst_pc_o       : byte PC of inst_o
//   inst_valid_o    : head valid
//   inst_ready_i    : decode accepts the head
//   redirect_i      : one-cycle redirect request, target redirect_pc_i
//   halt_i          : one-cycle request to stop fetching
//   halted_o        : fetch unit is halted
// -----------------------------------------------------------------------------
module dlx_fetch_unit
    import dlx_pkg::*;
#(
    parameter int                 ADDR_W   = DLX_ADDR_W,
    parameter int                 DATA_W   = DLX_INST_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_en_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              halted_o
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(DLX_PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

    fetch_state_e                state_r;
    fetch_state_e                state_n_s;
    logic [ADDR_W-1:0]           pc_r;
    logic [ADDR_W-1:0]           pc_n_s;
    logic [ADDR_W-1:0]           target_s;
    logic                        push_s;
    logic                        pop_s;
    logic [1:0]                  count_s;
    logic [ADDR_W+DATA_W-1:0]    head_s;

    assign target_s = redirect_pc_i & ~ALIGN_MASK;
    assign pop_s    = inst_valid_o & inst_ready_i;

    // Capture only while fetching, never in a redirect cycle, and only when
    // the buffer has (or is about to have) room.
    always_comb begin
        push_s = 1'b0;
        if ((state_r == ST_FETCH) && !redirect_i) begin
            push_s = slot_free(count_s, pop_s);
        end else begin
            push_s = 1'b0;
        end
    end

    // Fetch FSM next state; redirect outranks halt.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_n_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_i) begin
                    state_n_s = ST_FETCH;
                end else if (halt_i) begin
                    state_n_s = ST_HALTED;
                end else begin
                    state_n_s = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (redirect_i) begin
                    state_n_s = ST_FETCH;
                end else begin
                    state_n_s = ST_HALTED;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Next PC: redirect target, sequential step on capture, else hold.
    // The increment wraps naturally at the top of the address space.
    always_comb begin
        pc_n_s = pc_r;
        if (redirect_i) begin
            pc_n_s = target_s;
        end else if (push_s) begin
            pc_n_s = pc_r + PC_STEP;
        end else begin
            pc_n_s = pc_r;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
        end
    end

    dlx_fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (redirect_i),
        .wr_data ({pc_r, imem_data_i}),
        .count   (count_s),
        .head    (head_s)
    );

    assign imem_addr_o  = {2'b00, pc_r[ADDR_W-1:2]};
    assign imem_en_o    = push_s;
    assign inst_valid_o = (count_s != 2'd0);
    assign inst_pc_o    = head_s[ADDR_W+DATA_W-1:DATA_W];
    assign inst_o       = head_s[DATA_W-1:0];
    assign halted_o     = (state_r == ST_HALTED);

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_dlx_fetch_unit
// Directed bench for dlx_fetch_unit. ROM model: word k holds 0xA0 + k.
// Instance u_dut uses RESET_PC = 0 and is driven from a cycle table;
// instance u_wrap uses RESET_PC = 0xFFFF_FFF8 for PC wrap and async reset.
// -----------------------------------------------------------------------------
module tb_dlx_fetch_unit;

    typedef struct {
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        hlt;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        en;
        logic [31:0] addr;
        logic        halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;

    logic [31:0] imem_addr, imem_data, inst, inst_pc, redirect_pc;
    logic        imem_en, inst_valid, inst_ready, redirect, halt, halted;

    logic [31:0] w_addr, w_data, w_inst, w_pc;
    logic        w_en, w_valid, w_halted;
    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic        w_halt = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    assign imem_data = 32'hA0 + imem_addr;
    assign w_data    = 32'hA0 + w_addr;

    dlx_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_en_o    (imem_en),
        .imem_data_i  (imem_data),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halt_i       (halt),
        .halted_o     (halted)
    );

    dlx_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i        (clk),
        .rst_n_i      (rst2_n),
        .imem_addr_o  (w_addr),
        .imem_en_o    (w_en),
        .imem_data_i  (w_data),
        .inst_o       (w_inst),
        .inst_pc_o    (w_pc),
        .inst_valid_o (w_valid),
        .inst_ready_i (w_ready),
        .redirect_i   (w_redirect),
        .redirect_pc_i(w_redirect_pc),
        .halt_i       (w_halt),
        .halted_o     (w_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rdr, input logic [31:0] rpc,
                       input logic hlt, input logic valid, input logic [31:0] pc,
                       input logic [31:0] ins, input logic en, input logic [31:0] addr,
                       input logic hd);
        vec_t v;
        v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
        v.valid = valid; v.pc = pc; v.inst = ins; v.en = en; v.addr = addr; v.halted = hd;
        vq.push_back(v);
    endtask

    initial begin
        // Each row: inputs for one cycle, and the outputs expected in that
        // cycle before the next rising edge. pc/inst only checked when valid.
        //   rdy rdr rpc       hlt  valid pc        inst      en   addr      halted
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0, 1'b0); // IDLE
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h0, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  32'hA0, 1'b1, 32'h1, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'hA1, 1'b1, 32'h2, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  32'hA2, 1'b1, 32'h3, 1'b0);
        // backpressure: buffer fills, PC freezes at 0x14
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC,  32'hA3, 1'b1, 32'h4, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'hA3, 1'b0, 32'h5, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC,  32'hA3, 1'b1, 32'h5, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 32'hA4, 1'b1, 32'h6, 1'b0);
        // redirect to 0x13 with 2 entries and a pop: 0x14 delivered, 0x18 dropped
        add(1'b1, 1'b1, 32'h13, 1'b0, 1'b1, 32'h14, 32'hA5, 1'b0, 32'h7, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h4, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 32'hA4, 1'b1, 32'h5, 1'b0);
        // halt with 2 entries buffered, then drain
        add(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'hA4, 1'b0, 32'h6, 1'b0);
        add(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 32'hA4, 1'b0, 32'h6, 1'b1);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 32'hA4, 1'b0, 32'h6, 1'b1);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h14, 32'hA5, 1'b0, 32'h6, 1'b1);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h6, 1'b1);
        // resume by redirect to 0x20
        add(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 32'h6, 1'b1);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h8, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 32'hA8, 1'b1, 32'h9, 1'b0);
        // halt and redirect together: redirect wins
        add(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h24, 32'hA9, 1'b0, 32'hA, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h10, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 32'hB0, 1'b1, 32'h11, 1'b0);
        add(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h44, 32'hB1, 1'b1, 32'h12, 1'b0);

        inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst valid", {31'h0, inst_valid}, 32'h0);
        chk("rst inst", inst, 32'h0);
        chk("rst pc", inst_pc, 32'h0);
        chk("rst en", {31'h0, imem_en}, 32'h0);
        chk("rst halted", {31'h0, halted}, 32'h0);
        chk("rst addr", imem_addr, 32'h0);
        chk("rst2 addr", w_addr, 32'h3FFF_FFFE);
        rst_n = 1'b1;

        // Table-driven run of the main instance
        for (int i = 0; i < vq.size(); i++) begin
            inst_ready  = vq[i].rdy;
            redirect    = vq[i].rdr;
            redirect_pc = vq[i].rpc;
            halt        = vq[i].hlt;
            #1;
            chk($sformatf("row%0d valid", i), {31'h0, inst_valid}, {31'h0, vq[i].valid});
            chk($sformatf("row%0d en", i), {31'h0, imem_en}, {31'h0, vq[i].en});
            chk($sformatf("row%0d addr", i), imem_addr, vq[i].addr);
            chk($sformatf("row%0d halted", i), {31'h0, halted}, {31'h0, vq[i].halted});
            if (vq[i].valid) begin
                chk($sformatf("row%0d pc", i), inst_pc, vq[i].pc);
                chk($sformatf("row%0d inst", i), inst, vq[i].inst);
            end
            @(negedge clk);
        end
        redirect = 1'b0; halt = 1'b0;

        // PC wrap sequence on the second instance
        rst2_n = 1'b1;
        #1;
        chk("wrap idle en", {31'h0, w_en}, 32'h0);
        chk("wrap idle addr", w_addr, 32'h3FFF_FFFE);
        @(negedge clk); #1;
        chk("wrap c1 valid", {31'h0, w_valid}, 32'h0);
        chk("wrap c1 en", {31'h0, w_en}, 32'h1);
        @(negedge clk); #1;
        chk("wrap c2 valid", {31'h0, w_valid}, 32'h1);
        chk("wrap c2 pc", w_pc, 32'hFFFF_FFF8);
        chk("wrap c2 inst", w_inst, 32'h4000_009E);
        @(negedge clk); #1;
        chk("wrap c3 pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap c3 inst", w_inst, 32'h4000_009F);
        @(negedge clk); #1;
        chk("wrap c4 pc", w_pc, 32'h0);
        chk("wrap c4 inst", w_inst, 32'hA0);
        chk("wrap c4 valid", {31'h0, w_valid}, 32'h1);
        chk("wrap c4 addr", w_addr, 32'h1);
        // Asynchronous reset mid-stream, checked before the next rising edge
        rst2_n = 1'b0;
        #1;
        chk("async valid", {31'h0, w_valid}, 32'h0);
        chk("async inst", w_inst, 32'h0);
        chk("async pc", w_pc, 32'h0);
        chk("async addr", w_addr, 32'h3FFF_FFFE);
        chk("async en", {31'h0, w_en}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
